// File: rtl/downstream_vc_tracker_pkg.sv
// Shared NoC sizing and the per-VC ownership states used by the downstream VC tracker.
package noc_params;

   localparam int VC_NUM      = 2;
   localparam int PORT_NUM    = 5;
   localparam int VC_TOTAL    = PORT_NUM * VC_NUM;
   localparam int BUFFER_SIZE = 8;
   localparam int CNT_W       = $clog2(BUFFER_SIZE + 1);

   typedef logic [CNT_W-1:0]    count_t;
   typedef logic [VC_TOTAL-1:0] vc_vec_t;

   localparam count_t COUNT_MAX = count_t'(BUFFER_SIZE);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      ACTIVE   = 2'd1,
      DRAINING = 2'd2
   } vc_state_t;

endpackage

// File: rtl/downstream_vc_tracker_if.sv
// Bundle of per-VC event pulses into the tracker and its status vectors back out.
interface downstream_vc_tracker_if;
   import noc_params::*;

   vc_vec_t vc_allocated_i;
   vc_vec_t flit_sent_i;
   vc_vec_t tail_sent_i;
   vc_vec_t credit_i;
   vc_vec_t idle_downstream_vc_o;
   vc_vec_t credit_available_o;
   logic    error_o;

   modport master (
      output vc_allocated_i,
      output flit_sent_i,
      output tail_sent_i,
      output credit_i,
      input  idle_downstream_vc_o,
      input  credit_available_o,
      input  error_o
   );

   modport slave (
      input  vc_allocated_i,
      input  flit_sent_i,
      input  tail_sent_i,
      input  credit_i,
      output idle_downstream_vc_o,
      output credit_available_o,
      output error_o
   );

endinterface

// File: rtl/downstream_vc_tracker_credit_counter.sv
// Single downstream VC: credit counter, IDLE/ACTIVE/DRAINING ownership FSM and a
// combinational protocol-violation pulse for the current cycle.
module downstream_vc_credit_counter
   import noc_params::*;
(
   input  logic clk,
   input  logic rst,
   input  logic i_alloc,
   input  logic i_flit,
   input  logic i_tail,
   input  logic i_credit,
   output logic o_idle,
   output logic o_creditAvailable,
   output logic o_error
);

   count_t    r_count;
   vc_state_t r_state;

   count_t    w_nextCount;
   vc_state_t w_nextState;
   logic      w_sendLegal;
   logic      w_protoError;
   logic      w_underflow;
   logic      w_overflow;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_count <= COUNT_MAX;
         r_state <= IDLE;
      end else begin
         r_count <= w_nextCount;
         r_state <= w_nextState;
      end
   end

   // Flits are only honoured while ACTIVE; an illegal send flags an error and does not consume a credit.
   always_comb begin
      w_sendLegal  = i_flit && (r_state == ACTIVE);
      w_protoError = (i_alloc && (r_state != IDLE))
                   || (i_flit && (r_state != ACTIVE))
                   || (i_tail && !i_flit);
      w_underflow  = w_sendLegal && !i_credit && (r_count == '0);
      w_overflow   = i_credit && !w_sendLegal && (r_count == COUNT_MAX);

      w_nextCount = r_count;
      if (w_sendLegal && !i_credit && !w_underflow) begin
         w_nextCount = r_count - count_t'(1);
      end else if (i_credit && !w_sendLegal && !w_overflow) begin
         w_nextCount = r_count + count_t'(1);
      end

      w_nextState = r_state;
      case (r_state)
         IDLE: begin
            if (i_alloc) begin
               w_nextState = ACTIVE;
            end
         end
         ACTIVE: begin
            if (w_sendLegal && i_tail) begin
               w_nextState = (w_nextCount == COUNT_MAX) ? IDLE : DRAINING;
            end
         end
         DRAINING: begin
            if (w_nextCount == COUNT_MAX) begin
               w_nextState = IDLE;
            end
         end
         default: w_nextState = IDLE;
      endcase
   end

   assign o_idle            = (r_state == IDLE);
   assign o_creditAvailable = (r_count != '0);
   assign o_error           = w_protoError | w_underflow | w_overflow;

endmodule

// File: rtl/downstream_vc_tracker.sv
// Router output-side bookkeeping: one credit/ownership tracker per downstream VC plus
// a sticky error flag collecting every per-VC protocol violation.
module downstream_vc_tracker
   import noc_params::*;
(
   input  logic                   clk,
   input  logic                   rst,
   downstream_vc_tracker_if.slave bus
);

   vc_vec_t w_idle;
   vc_vec_t w_creditAvailable;
   vc_vec_t w_vcError;
   logic    r_error;

   for (genvar v = 0; v < VC_TOTAL; v++) begin : g_vc
      downstream_vc_credit_counter u_counter (
         .clk               (clk),
         .rst               (rst),
         .i_alloc           (bus.vc_allocated_i[v]),
         .i_flit            (bus.flit_sent_i[v]),
         .i_tail            (bus.tail_sent_i[v]),
         .i_credit          (bus.credit_i[v]),
         .o_idle            (w_idle[v]),
         .o_creditAvailable (w_creditAvailable[v]),
         .o_error           (w_vcError[v])
      );
   end

   // Once any VC misbehaves the flag stays up until the next reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_error <= 1'b0;
      end else begin
         r_error <= r_error | (|w_vcError);
      end
   end

   assign bus.idle_downstream_vc_o = w_idle;
   assign bus.credit_available_o   = w_creditAvailable;
   assign bus.error_o              = r_error;

endmodule

// File: tb/tb_downstream_vc_tracker.sv
// Directed scoreboard bench for downstream_vc_tracker: stimulus queues expected outputs,
// a negedge monitor pops and compares them.
module tb_downstream_vc_tracker;
   import noc_params::*;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   downstream_vc_tracker_if bus();

   downstream_vc_tracker dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      int      cyc;
      vc_vec_t idle;
      vc_vec_t avail;
      logic    err;
   } exp_t;

   exp_t  expQ[$];
   string nameQ[$];
   int    cycle       = 0;
   int    testsRun    = 0;
   int    testsFailed = 0;

   always @(posedge clk) cycle <= cycle + 1;

   function automatic vc_vec_t bitOf(input int v);
      return vc_vec_t'(1) << v;
   endfunction

   task automatic compareField(input string name, input string field,
                               input vc_vec_t act, input vc_vec_t exp);
      testsRun++;
      if (act !== exp) begin
         testsFailed++;
         $display("[TB] FAIL %s/%s: got %h expected %h", name, field, act, exp);
      end
   endtask

   // Monitor: every entry whose cycle has been reached is compared against the live outputs.
   always @(negedge clk) begin : monitor
      exp_t  e;
      string n;
      while (expQ.size() > 0 && expQ[0].cyc <= cycle) begin
         e = expQ.pop_front();
         n = nameQ.pop_front();
         compareField(n, "idle",  bus.idle_downstream_vc_o, e.idle);
         compareField(n, "avail", bus.credit_available_o,   e.avail);
         compareField(n, "err",   vc_vec_t'(bus.error_o),   vc_vec_t'(e.err));
      end
   end

   task automatic applyStimulus(input vc_vec_t alloc, input vc_vec_t flit,
                                input vc_vec_t tail, input vc_vec_t cred);
      bus.vc_allocated_i = alloc;
      bus.flit_sent_i    = flit;
      bus.tail_sent_i    = tail;
      bus.credit_i       = cred;
      @(posedge clk);
      #1;
      bus.vc_allocated_i = '0;
      bus.flit_sent_i    = '0;
      bus.tail_sent_i    = '0;
      bus.credit_i       = '0;
   endtask

   task automatic checkOutput(input string name, input vc_vec_t expIdle,
                              input vc_vec_t expAvail, input logic expErr);
      expQ.push_back('{cyc: cycle, idle: expIdle, avail: expAvail, err: expErr});
      nameQ.push_back(name);
   endtask

   task automatic doReset();
      @(negedge clk);
      #1 rst = 1'b0;
      @(posedge clk);
      #1 rst = 1'b1;
   endtask

   localparam vc_vec_t ALL = '1;

   initial begin
      bus.vc_allocated_i = '0;
      bus.flit_sent_i    = '0;
      bus.tail_sent_i    = '0;
      bus.credit_i       = '0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
      checkOutput("reset", ALL, ALL, 1'b0);

      // VC4: 3-flit packet then 3 credits back
      applyStimulus(bitOf(4), '0, '0, '0);
      checkOutput("vc4 grant", 10'h3EF, ALL, 1'b0);
      applyStimulus('0, bitOf(4), '0, '0);
      applyStimulus('0, bitOf(4), '0, '0);
      applyStimulus('0, bitOf(4), bitOf(4), '0);
      checkOutput("vc4 draining", 10'h3EF, ALL, 1'b0);
      applyStimulus('0, '0, '0, bitOf(4));
      applyStimulus('0, '0, '0, bitOf(4));
      checkOutput("vc4 two credits", 10'h3EF, ALL, 1'b0);
      applyStimulus('0, '0, '0, bitOf(4));
      checkOutput("vc4 idle again", ALL, ALL, 1'b0);

      // VC7: balanced send/credit, then a 1-flit packet that returns straight to IDLE
      applyStimulus(bitOf(7), '0, '0, '0);
      for (int i = 0; i < 5; i++) applyStimulus('0, bitOf(7), '0, bitOf(7));
      checkOutput("vc7 balanced", 10'h37F, ALL, 1'b0);
      applyStimulus('0, bitOf(7), bitOf(7), bitOf(7));
      checkOutput("vc7 direct idle", ALL, ALL, 1'b0);

      // VC3: asynchronous reset in the middle of a packet
      applyStimulus(bitOf(3), '0, '0, '0);
      applyStimulus('0, bitOf(3), '0, '0);
      applyStimulus('0, bitOf(3), '0, '0);
      checkOutput("vc3 owned", 10'h3F7, ALL, 1'b0);
      @(negedge clk);
      #1 rst = 1'b0;
      checkOutput("vc3 async reset", ALL, ALL, 1'b0);
      @(negedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1;
      applyStimulus(bitOf(3), '0, '0, '0);
      applyStimulus('0, bitOf(3), bitOf(3), bitOf(3));
      checkOutput("vc3 count restored", ALL, ALL, 1'b0);

      // VC0: exhaust all credits, then underflow
      applyStimulus(bitOf(0), '0, '0, '0);
      for (int i = 0; i < 7; i++) applyStimulus('0, bitOf(0), '0, '0);
      checkOutput("vc0 count 1", 10'h3FE, ALL, 1'b0);
      applyStimulus('0, bitOf(0), '0, '0);
      checkOutput("vc0 count 0", 10'h3FE, 10'h3FE, 1'b0);
      applyStimulus('0, bitOf(0), '0, '0);
      checkOutput("vc0 underflow", 10'h3FE, 10'h3FE, 1'b1);
      applyStimulus('0, '0, '0, bitOf(0));
      checkOutput("vc0 credit after underflow", 10'h3FE, ALL, 1'b1);
      applyStimulus('0, bitOf(0), '0, '0);
      checkOutput("vc0 held at zero", 10'h3FE, 10'h3FE, 1'b1);
      doReset();

      // Protocol violations, each from a clean reset
      applyStimulus(bitOf(2), '0, '0, '0);
      checkOutput("vc2 first grant", 10'h3FB, ALL, 1'b0);
      applyStimulus(bitOf(2), '0, '0, '0);
      checkOutput("vc2 double grant", 10'h3FB, ALL, 1'b1);
      doReset();
      applyStimulus('0, bitOf(5), '0, '0);
      checkOutput("vc5 send while idle", ALL, ALL, 1'b1);
      doReset();
      applyStimulus('0, '0, '0, bitOf(1));
      checkOutput("vc1 overflow", ALL, ALL, 1'b1);
      applyStimulus(bitOf(1), '0, '0, '0);
      checkOutput("vc1 grant after overflow", 10'h3FD, ALL, 1'b1);
      applyStimulus('0, bitOf(1), bitOf(1), bitOf(1));
      checkOutput("vc1 count held at max", ALL, ALL, 1'b1);
      doReset();
      applyStimulus(bitOf(6), '0, '0, '0);
      applyStimulus('0, '0, bitOf(6), '0);
      checkOutput("vc6 tail without flit", 10'h3BF, ALL, 1'b1);
      doReset();

      // All VCs granted together, then released independently
      applyStimulus(ALL, '0, '0, '0);
      checkOutput("all granted", 10'h000, ALL, 1'b0);
      applyStimulus('0, 10'h155, 10'h155, '0);
      checkOutput("even tails", 10'h000, ALL, 1'b0);
      applyStimulus('0, '0, '0, 10'h011);
      checkOutput("vc0 vc4 released", 10'h011, ALL, 1'b0);
      applyStimulus('0, 10'h00A, 10'h00A, 10'h00E);
      checkOutput("vc1 vc2 vc3 released", 10'h01F, ALL, 1'b0);
      applyStimulus('0, 10'h020, '0, 10'h140);
      checkOutput("vc6 vc8 released", 10'h15F, ALL, 1'b0);
      applyStimulus('0, bitOf(5), bitOf(5), '0);
      applyStimulus('0, '0, '0, bitOf(5));
      checkOutput("vc5 draining", 10'h15F, ALL, 1'b0);
      applyStimulus('0, '0, '0, bitOf(5));
      checkOutput("vc5 released", 10'h17F, ALL, 1'b0);

      for (int i = 0; i < 20 && expQ.size() > 0; i++) @(negedge clk);
      #1;
      if (expQ.size() > 0) begin
         testsRun++;
         testsFailed++;
         $display("[TB] FAIL drain: %0d checks pending, expected 0", expQ.size());
      end
      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
